// File: rtl/dpcm_decoder.sv
// dpcm_decoder: rebuilds 8-bit samples from a signed-magnitude DPCM stream.
// A frame opens with an absolute key sample. Each following delta is
// clipped to MAX_DELTA, then added to the previous sample or subtracted
// from it. The result is clamped to 0..255.
//
// Handshake: a word on the input side is accepted on a rising edge where
// Valid && Ready. The output register is consumed on a rising edge where
// OutValid && OutReady. Ready depends on rst, OutValid and OutReady only,
// never on Valid. While the output register is full and not being drained,
// Ready stays low and DataOut/OutValid hold.
module dpcm_decoder #(
  parameter int MAX_DELTA = 200,
  parameter int FRAME_LEN = 64,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Valid,
  output logic             Ready,
  input  logic             Key,
  input  logic [8:0]       DataIn,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [7:0]       DataOut,
  output logic [CNT_W-1:0] SatCount,
  output logic [CNT_W-1:0] DropCount,
  output logic             DbgState
);

  typedef enum logic {
    KEY_WAIT = 1'b0,
    RUN      = 1'b1
  } state_t;

  // The frame counter only needs to reach FRAME_LEN. Keep it at least 1 bit wide.
  localparam int FC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN + 1) : 1;
  localparam logic [FC_W-1:0] FRAME_END = FC_W'(FRAME_LEN);
  localparam logic [7:0]      MAX_MAG   = 8'(MAX_DELTA);

  state_t            state, stateNext;
  logic [7:0]        prev, prevNext;
  logic [7:0]        dataNext;
  logic              outValidNext;
  logic [FC_W-1:0]   frameCnt, frameNext;
  logic [CNT_W-1:0]  satNext, dropNext;

  logic              accept;
  logic              clipped;
  logic              clamped;
  logic [7:0]        mag;
  logic [9:0]        sum;
  logic [7:0]        deltaRes;
  logic              produced;

  assign Ready    = rst && (!OutValid || OutReady);
  assign accept   = Valid && Ready;
  assign DbgState = (state == RUN);

  // Delta datapath: clip the magnitude, then apply it to prev and clamp.
  // The 10-bit sum ranges from -200 to 455. Bit 9 flags a negative sum.
  // When bit 9 is clear, bit 8 flags an overflow above 255.
  always_comb begin
    clipped  = (DataIn[7:0] > MAX_MAG);
    mag      = clipped ? MAX_MAG : DataIn[7:0];
    sum      = DataIn[8] ? ({2'b00, prev} - {2'b00, mag})
                         : ({2'b00, prev} + {2'b00, mag});
    clamped  = 1'b0;
    deltaRes = sum[7:0];
    if (sum[9]) begin
      deltaRes = 8'd0;
      clamped  = 1'b1;
    end else if (sum[8]) begin
      deltaRes = 8'd255;
      clamped  = 1'b1;
    end
  end

  // Next-state and next-register values for the FSM and datapath registers.
  always_comb begin
    stateNext    = state;
    prevNext     = prev;
    dataNext     = DataOut;
    outValidNext = OutValid && !OutReady;
    frameNext    = frameCnt;
    satNext      = SatCount;
    dropNext     = DropCount;
    produced     = 1'b0;

    if (accept) begin
      if (Key) begin
        // A key word both starts a frame and resynchronises a running one.
        prevNext     = DataIn[7:0];
        dataNext     = DataIn[7:0];
        outValidNext = 1'b1;
        frameNext    = FC_W'(1);
        stateNext    = RUN;
        produced     = 1'b1;
      end else if (state == KEY_WAIT) begin
        // A delta with no reference sample is discarded. The output register is untouched.
        if (DropCount != '1) dropNext = DropCount + 1'b1;
      end else begin
        prevNext     = deltaRes;
        dataNext     = deltaRes;
        outValidNext = 1'b1;
        frameNext    = frameCnt + 1'b1;
        produced     = 1'b1;
        if ((clipped || clamped) && (SatCount != '1)) satNext = SatCount + 1'b1;
      end

      if (produced && (FRAME_LEN != 0) && (frameNext == FRAME_END)) begin
        stateNext = KEY_WAIT;
      end
    end
  end

  // State and datapath registers, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= KEY_WAIT;
      prev      <= 8'd0;
      DataOut   <= 8'd0;
      OutValid  <= 1'b0;
      frameCnt  <= '0;
      SatCount  <= '0;
      DropCount <= '0;
    end else begin
      state     <= stateNext;
      prev      <= prevNext;
      DataOut   <= dataNext;
      OutValid  <= outValidNext;
      frameCnt  <= frameNext;
      SatCount  <= satNext;
      DropCount <= dropNext;
    end
  end

endmodule

// File: tb/tb_dpcm_decoder.sv
// tb_dpcm_decoder: directed checks of dpcm_decoder with FRAME_LEN = 4.
// Expected values are worked out by hand from the decoding rules.
module tb_dpcm_decoder;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             Valid;
  logic             Ready;
  logic             Key;
  logic [8:0]       DataIn;
  logic             OutValid;
  logic             OutReady;
  logic [7:0]       DataOut;
  logic [CNT_W-1:0] SatCount;
  logic [CNT_W-1:0] DropCount;
  logic             DbgState;

  int cmpCount = 0;
  int errCount = 0;
  logic [7:0] expQ[$];

  dpcm_decoder #(
    .MAX_DELTA(200),
    .FRAME_LEN(4),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .Valid(Valid),
    .Ready(Ready),
    .Key(Key),
    .DataIn(DataIn),
    .OutValid(OutValid),
    .OutReady(OutReady),
    .DataOut(DataOut),
    .SatCount(SatCount),
    .DropCount(DropCount),
    .DbgState(DbgState)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmpCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Driver tasks. Each call takes one clock and leaves the bench at edge + 1.
  task automatic send(input logic k, input logic [8:0] d);
    Valid  = 1'b1;
    Key    = k;
    DataIn = d;
    @(posedge clk);
    #1;
    Valid  = 1'b0;
    Key    = 1'b0;
  endtask

  task automatic pulseRst();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Directed sequence
  initial begin
    logic [8:0] nxt[3];
    nxt[0] = 9'd8;
    nxt[1] = 9'd9;
    nxt[2] = 9'd0;

    rst = 1'b0; Valid = 1'b0; Key = 1'b0; DataIn = 9'd0; OutReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outvalid", 32'(OutValid), 32'd0);
    chk("rst_dataout", 32'(DataOut), 32'd0);
    chk("rst_sat", 32'(SatCount), 32'd0);
    chk("rst_drop", 32'(DropCount), 32'd0);
    chk("rst_state", 32'(DbgState), 32'd0);
    chk("rst_ready_low", 32'(Ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("ready_idle", 32'(Ready), 32'd1);

    // Key 100, +20, -50, +0. This is a full 4-sample frame.
    send(1'b1, 9'd100);
    chk("basic_key", 32'(DataOut), 32'd100);
    chk("basic_ov", 32'(OutValid), 32'd1);
    send(1'b0, 9'd20);
    chk("basic_p20", 32'(DataOut), 32'd120);
    send(1'b0, {1'b1, 8'd50});
    chk("basic_m50", 32'(DataOut), 32'd70);
    send(1'b0, 9'd0);
    chk("basic_p0", 32'(DataOut), 32'd70);
    chk("basic_frame_end", 32'(DbgState), 32'd0);
    @(posedge clk);
    #1;
    chk("drain_ov", 32'(OutValid), 32'd0);
    chk("drain_hold", 32'(DataOut), 32'd70);

    // Clamping and clipping
    send(1'b1, 9'd250);
    chk("clamp_key", 32'(DataOut), 32'd250);
    send(1'b0, 9'd10);
    chk("clamp_hi", 32'(DataOut), 32'd255);
    chk("clamp_hi_sat", 32'(SatCount), 32'd1);
    send(1'b0, {1'b1, 8'd255});
    chk("clip_m255", 32'(DataOut), 32'd55);
    chk("clip_sat", 32'(SatCount), 32'd2);
    send(1'b1, 9'd5);
    chk("resync_key", 32'(DataOut), 32'd5);
    send(1'b0, {1'b1, 8'd10});
    chk("clamp_lo", 32'(DataOut), 32'd0);
    chk("clamp_lo_sat", 32'(SatCount), 32'd3);
    chk("run_state", 32'(DbgState), 32'd1);

    // Reset while the output register is full
    chk("pre_rst_ov", 32'(OutValid), 32'd1);
    pulseRst();
    chk("midrst_ov", 32'(OutValid), 32'd0);
    chk("midrst_data", 32'(DataOut), 32'd0);
    chk("midrst_sat", 32'(SatCount), 32'd0);
    chk("midrst_drop", 32'(DropCount), 32'd0);
    chk("midrst_state", 32'(DbgState), 32'd0);
    send(1'b0, 9'd5);
    chk("postrst_drop_ov", 32'(OutValid), 32'd0);
    chk("postrst_drop_cnt", 32'(DropCount), 32'd1);

    // Key wait: three deltas are dropped, then key 42 arrives.
    pulseRst();
    send(1'b0, 9'd3);
    send(1'b0, {1'b1, 8'd4});
    send(1'b0, 9'd200);
    chk("kw_drop3", 32'(DropCount), 32'd3);
    chk("kw_no_out", 32'(OutValid), 32'd0);
    send(1'b1, 9'd42);
    chk("kw_key42", 32'(DataOut), 32'd42);
    chk("kw_key42_ov", 32'(OutValid), 32'd1);
    chk("kw_sat_clean", 32'(SatCount), 32'd0);

    // Frame boundary at FRAME_LEN = 4
    pulseRst();
    send(1'b1, 9'd10);
    chk("fr_key10", 32'(DataOut), 32'd10);
    send(1'b0, 9'd1);
    chk("fr_11", 32'(DataOut), 32'd11);
    send(1'b0, 9'd1);
    chk("fr_12", 32'(DataOut), 32'd12);
    send(1'b0, 9'd1);
    chk("fr_13", 32'(DataOut), 32'd13);
    chk("fr_end_state", 32'(DbgState), 32'd0);
    send(1'b0, 9'd1);
    chk("fr_drop_cnt", 32'(DropCount), 32'd1);
    chk("fr_drop_data", 32'(DataOut), 32'd13);
    chk("fr_drop_ov", 32'(OutValid), 32'd0);
    send(1'b1, 9'd0);
    chk("fr_key0", 32'(DataOut), 32'd0);
    chk("fr_key0_ov", 32'(OutValid), 32'd1);

    // Backpressure: the output holds key 0 while +7 waits on the input.
    expQ.push_back(8'd0);
    expQ.push_back(8'd7);
    expQ.push_back(8'd15);
    expQ.push_back(8'd24);
    OutReady = 1'b0;
    Valid    = 1'b1;
    Key      = 1'b0;
    DataIn   = 9'd7;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready", 32'(Ready), 32'd0);
      chk("bp_data", 32'(DataOut), 32'd0);
      chk("bp_ov", 32'(OutValid), 32'd1);
      @(posedge clk);
      #1;
    end
    OutReady = 1'b1;
    #1;
    chk("bp_release_ready", 32'(Ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_stream_ov", 32'(OutValid), 32'd1);
      chk("bp_stream_data", 32'(DataOut), 32'(expQ.pop_front()));
      if (i == 1 || i == 2) DataIn = nxt[i-1];
      if (i == 3) Valid = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("bp_all_out", 32'(expQ.size()), 32'd0);
    chk("bp_final_ov", 32'(OutValid), 32'd0);
    chk("bp_frame_end", 32'(DbgState), 32'd0);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule

// File: doc/dpcm_decoder.md
# dpcm_decoder

Reconstructs 8-bit samples from a signed-magnitude DPCM delta stream and is the receive-side counterpart of the team's DPCM encoder. Each frame starts with an absolute key sample, followed by deltas that are accumulated onto the previous reconstructed sample with clamping to 0..255. Input and output use Valid/Ready handshakes, with a single registered output stage. Sits between the DDLS link receiver and the sample sink.

## Interface
- MAX_DELTA, 200: delta magnitude ceiling; larger magnitudes are clipped to it (matches encoder saturation).
- FRAME_LEN, 64: samples per frame including the key sample; 0 = unbounded frame (key needed only after reset).
- CNT_W, 16: width of the status counters.

- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset: synchronous, active-low.
- Valid  in  1  input word present.
- Ready  out  1  decoder can accept a word this cycle.
- Key  in  1  qualifies DataIn as an absolute key sample; sampled with Valid.
- DataIn  in  9  bit 8 = sign (1 = subtract), bits 7:0 = magnitude; for key words, bits 7:0 = absolute sample and bit 8 is ignored.
- OutValid  out  1  DataOut holds a reconstructed sample.
- OutReady  in  1  sink accepts DataOut.
- DataOut  out  8  reconstructed sample.
- SatCount  out  CNT_W  count of results clamped at 0 or 255, or of magnitudes clipped to MAX_DELTA; saturates at all-ones.
- DropCount  out  CNT_W  count of deltas discarded while waiting for a key; saturates at all-ones.

## Operation
- States:
  - KEY_WAIT (reset state).
  - RUN.
- Accept: a word is accepted when Valid && Ready.
- KEY_WAIT:
  - Accepted Key word: prev <= DataIn[7:0]; DataOut <= DataIn[7:0]; OutValid <= 1; frame count <= 1; go to RUN.
  - Accepted non-key word: discarded, no output, DropCount++.
- RUN, accepted Key word: resynchronise. Same action as in KEY_WAIT; stay in RUN.
- RUN, accepted delta:
  - Clipping: mag = min(DataIn[7:0], MAX_DELTA).
  - Compute in 10-bit signed arithmetic: sum = prev + mag, or prev − mag when the sign bit is set.
  - Clamping: sum < 0 -> 0; sum > 255 -> 255.
  - Result goes to prev and DataOut; OutValid <= 1; frame count++.
- SatCount increments by 1 (not 2) per delta that was clipped, clamped, or both.
- Frame end: when FRAME_LEN != 0 and the frame count reaches FRAME_LEN after an accept, go to KEY_WAIT. A key arriving exactly at the frame boundary is legal.
- Output drain: OutValid clears on OutValid && OutReady unless a new word is accepted in the same cycle.
- Dropped words never disturb OutValid or DataOut.

## Timing
- Ready = rst && (!OutValid || OutReady).
  - Combinational from OutReady; no combinational path from Valid.
  - Ready is 0 while rst is low.
- Latency: a word accepted at edge N appears on DataOut with OutValid = 1 after edge N.
- Throughput: 1 word/cycle sustained while OutReady = 1.
- Backpressure: with OutValid = 1 and OutReady = 0, Ready = 0, and DataOut and OutValid are held stable.
- Simultaneous output handshake and new accept in one cycle: DataOut is replaced, and OutValid stays 1.
- Reset values while rst = 0 at an edge:
  - State = KEY_WAIT.
  - prev = 0, DataOut = 0, OutValid = 0.
  - Frame count = 0, SatCount = 0, DropCount = 0.
- Reset mid-frame or mid-backpressure discards any pending output. The next frame must begin with a key.
- Counters are held at all-ones once saturated; they are cleared only by reset.

## Test plan
- Key/delta basic: key 100, then +20, −50, +0 with OutReady = 1 -> DataOut 100, 120, 70, 70 on consecutive cycles.
- Clamping: key 250, +10, −255 -> 255, then 55 (magnitude clipped to 200), SatCount = 2. Then key 5, −10 -> 0, SatCount = 3.
- Key wait and drop: after reset, send 3 deltas then key 42 -> 3 dropped, DropCount = 3, first output 42.
- Frame boundary, FRAME_LEN = 4:
  - Send key 10, +1, +1, +1, then delta +1 -> outputs 10, 11, 12, 13; the fifth word is dropped with DropCount = 1.
  - A following key 0 is output as 0.
- Backpressure: hold OutReady = 0 for 5 cycles with Valid = 1 -> Ready = 0, DataOut stable, no word lost. On release, outputs continue 1/cycle in order.
- Reset mid-stream: assert rst low for 1 cycle while OutValid = 1 -> OutValid = 0, counters 0, and the next delta is dropped until a key arrives.
